// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash responder serving READ (0x03) from a byte memory.
// Pins are oversampled in the clk domain; clk must run >= 8x flash_clk.
module spi_flash_responder #(
  parameter int          ADDR_WIDTH = 12,
  parameter logic [7:0]  CMD_READ   = 8'h03
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flash_clk,
  input  logic                  flash_cs,
  input  logic                  flash_mosi,
  output logic                  flash_miso,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [7:0]            mem_data,
  output logic                  busy,
  output logic                  cmd_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DATA,
    S_IGNORE
  } state_t;

  logic [1:0] sclk_s_q;
  logic       sclk_prev_q;
  logic [1:0] cs_s_q;
  logic [1:0] mosi_s_q;

  state_t                state_q, state_d;
  logic [4:0]            cnt_q, cnt_d;
  logic [22:0]           sh_q, sh_d;
  logic [7:0]            tx_q, tx_d;
  logic                  miso_q, miso_d;
  logic                  rd_q, rd_d;
  logic                  rd_dly_q;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;
  logic                  armed_q, armed_d;

  logic cs_hi;
  logic rise;
  logic fall;
  logic mosi;

  assign cs_hi = cs_s_q[1];
  assign mosi  = mosi_s_q[1];
  assign rise  = sclk_s_q[1] & ~sclk_prev_q & ~cs_hi;
  assign fall  = ~sclk_s_q[1] & sclk_prev_q & ~cs_hi;

  // cs sync resets low so a cs held low through reset is not taken as a new frame
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_s_q    <= 2'b00;
      sclk_prev_q <= 1'b0;
      cs_s_q      <= 2'b00;
      mosi_s_q    <= 2'b00;
    end else begin
      sclk_s_q    <= {sclk_s_q[0], flash_clk};
      sclk_prev_q <= sclk_s_q[1];
      cs_s_q      <= {cs_s_q[0], flash_cs};
      mosi_s_q    <= {mosi_s_q[0], flash_mosi};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      sh_q     <= '0;
      tx_q     <= '0;
      miso_q   <= 1'b1;
      rd_q     <= 1'b0;
      rd_dly_q <= 1'b0;
      addr_q   <= '0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sh_q     <= sh_d;
      tx_q     <= tx_d;
      miso_q   <= miso_d;
      rd_q     <= rd_d;
      rd_dly_q <= rd_q;
      addr_q   <= addr_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      armed_q  <= armed_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    miso_d  = miso_q;
    rd_d    = 1'b0;
    addr_d  = addr_q;
    busy_d  = busy_q;
    err_d   = 1'b0;
    armed_d = armed_q;

    // memory answers one cycle after the strobe
    if (rd_dly_q) begin
      tx_d = mem_data;
    end

    unique case (state_q)
      S_IDLE: begin
        miso_d = 1'b1;
        cnt_d  = '0;
        if (cs_hi) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d = S_CMD;
          busy_d  = 1'b1;
        end
      end
      S_CMD: begin
        if (rise) begin
          sh_d  = {sh_q[21:0], mosi};
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd7) begin
            cnt_d = '0;
            if ({sh_q[6:0], mosi} == CMD_READ) begin
              state_d = S_ADDR;
            end else begin
              err_d   = 1'b1;
              state_d = S_IGNORE;
            end
          end
        end
      end
      S_ADDR: begin
        if (rise) begin
          sh_d  = {sh_q[21:0], mosi};
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd23) begin
            cnt_d   = '0;
            addr_d  = ADDR_WIDTH'({sh_q, mosi});
            rd_d    = 1'b1;
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (fall) begin
          miso_d = tx_q[7];
          tx_d   = {tx_q[6:0], 1'b0};
          cnt_d  = cnt_q + 5'd1;
          if (cnt_q == 5'd7) begin
            cnt_d  = '0;
            addr_d = addr_q + 1'b1;
            rd_d   = 1'b1;
          end
        end
      end
      S_IGNORE: begin
        miso_d = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (cs_hi && state_q != S_IDLE) begin
      state_d = S_IDLE;
      miso_d  = 1'b1;
      busy_d  = 1'b0;
      cnt_d   = '0;
    end
  end

  assign flash_miso = miso_q;
  assign mem_rd     = rd_q;
  assign mem_addr   = addr_q;
  assign busy       = busy_q;
  assign cmd_err    = err_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: a 12-bit and a 4-bit address
// instance share the SPI pins, each with its own byte memory.
module tb_spi_flash_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        sclk;
  logic        cs;
  logic        mosi;
  logic        miso12, rd12, busy12, err12;
  logic [11:0] addr12;
  logic [7:0]  data12;
  logic        miso4, rd4, busy4, err4;
  logic [3:0]  addr4;
  logic [7:0]  data4;

  logic [7:0] mem12 [4096];
  logic [7:0] mem4  [16];

  int rd_cnt12, rd_cnt4, err_cnt12, err_cnt4, last12, last4;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_flash_responder #(.ADDR_WIDTH(12), .CMD_READ(8'h03)) u_dut (
    .clk(clk), .rst(rst), .flash_clk(sclk), .flash_cs(cs),
    .flash_mosi(mosi), .flash_miso(miso12), .mem_rd(rd12),
    .mem_addr(addr12), .mem_data(data12), .busy(busy12),
    .cmd_err(err12)
  );

  spi_flash_responder #(.ADDR_WIDTH(4), .CMD_READ(8'h03)) u_dut4 (
    .clk(clk), .rst(rst), .flash_clk(sclk), .flash_cs(cs),
    .flash_mosi(mosi), .flash_miso(miso4), .mem_rd(rd4),
    .mem_addr(addr4), .mem_data(data4), .busy(busy4),
    .cmd_err(err4)
  );

  always @(posedge clk) begin
    if (rd12) begin
      data12 <= mem12[addr12];
      rd_cnt12 = rd_cnt12 + 1;
      last12 = int'(addr12);
    end
    if (rd4) begin
      data4 <= mem4[addr4];
      rd_cnt4 = rd_cnt4 + 1;
      last4 = int'(addr4);
    end
    if (err12) err_cnt12 = err_cnt12 + 1;
    if (err4) err_cnt4 = err_cnt4 + 1;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clr_counts();
    rd_cnt12 = 0; rd_cnt4 = 0;
    err_cnt12 = 0; err_cnt4 = 0;
    last12 = -1; last4 = -1;
  endtask

  // one mode-0 bit: mosi set with clock low, miso sampled at the rise
  task automatic spi_bit(input logic mo, output logic m12,
                         output logic m4);
    mosi = mo;
    repeat (4) @(negedge clk);
    sclk = 1'b1;
    m12 = miso12;
    m4 = miso4;
    repeat (4) @(negedge clk);
    sclk = 1'b0;
  endtask

  task automatic send_hdr(input logic [7:0] op, input logic [23:0] a,
                          input int nabits, output logic hi);
    logic m12, m4;
    hi = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(op[i], m12, m4);
      hi = hi & m12 & m4;
    end
    for (int i = 23; i > 23 - nabits; i--) begin
      spi_bit(a[i], m12, m4);
      hi = hi & m12 & m4;
    end
  endtask

  task automatic run_xfer(input logic [7:0] op, input logic [23:0] a,
                          input int nb, output logic [15:0] rx12,
                          output logic [15:0] rx4, output logic hi);
    logic m12, m4;
    rx12 = '0;
    rx4 = '0;
    cs = 1'b0;
    repeat (8) @(negedge clk);
    send_hdr(op, a, 24, hi);
    for (int i = 0; i < nb * 8; i++) begin
      spi_bit(1'b0, m12, m4);
      rx12 = {rx12[14:0], m12};
      rx4 = {rx4[14:0], m4};
    end
    repeat (4) @(negedge clk);
    cs = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [23:0] addr;
    int          nb;
    bit          w4;
    logic [15:0] exp;
    int          exp_rd;
    int          exp_err;
    int          exp_last;
  } vec_t;

  vec_t vecs [5];

  initial begin
    logic [15:0] rx12, rx4, rx;
    logic hi, m12, m4, all_hi;
    int rdc, errc, lastv;

    for (int i = 0; i < 4096; i++) mem12[i] = 8'(i) ^ 8'h5C;
    for (int i = 0; i < 16; i++) mem4[i] = 8'(i) ^ 8'hC3;
    mem12[0] = 8'hA5; mem12[1] = 8'h3C;
    mem12[2] = 8'h5A; mem12[3] = 8'h77;
    mem4[15] = 8'h11; mem4[0] = 8'h22; mem4[1] = 8'h33;
    data12 = 8'h00; data4 = 8'h00;

    vecs[0] = '{8'h03, 24'h000000, 2, 1'b0, 16'hA53C, 3, 0, 2};
    vecs[1] = '{8'h9F, 24'h000000, 1, 1'b0, 16'h00FF, 0, 1, -1};
    vecs[2] = '{8'h03, 24'h00000F, 2, 1'b1, 16'h1122, 3, 0, 1};
    vecs[3] = '{8'h03, 24'hFF0002, 1, 1'b0, 16'h005A, 2, 0, 3};
    vecs[4] = '{8'h03, 24'h000003, 1, 1'b0, 16'h0077, 2, 0, 4};

    clr_counts();
    rst = 1'b1; cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
    repeat (4) @(negedge clk);
    chk("reset_miso", 32'(miso12), 32'h1);
    chk("reset_busy", 32'(busy12), 32'h0);
    chk("reset_mem_rd", 32'(rd12), 32'h0);
    chk("reset_cmd_err", 32'(err12), 32'h0);
    chk("reset_mem_addr", 32'(addr12), 32'h0);
    chk("reset_miso4", 32'(miso4), 32'h1);
    rst = 1'b0;
    repeat (8) @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      clr_counts();
      run_xfer(vecs[v].op, vecs[v].addr, vecs[v].nb, rx12, rx4, hi);
      rx = vecs[v].w4 ? rx4 : rx12;
      rdc = vecs[v].w4 ? rd_cnt4 : rd_cnt12;
      errc = vecs[v].w4 ? err_cnt4 : err_cnt12;
      lastv = vecs[v].w4 ? last4 : last12;
      chk($sformatf("v%0d_data", v), 32'(rx), 32'(vecs[v].exp));
      chk($sformatf("v%0d_rd_count", v), 32'(rdc), 32'(vecs[v].exp_rd));
      chk($sformatf("v%0d_cmd_err", v), 32'(errc), 32'(vecs[v].exp_err));
      chk($sformatf("v%0d_hdr_miso", v), 32'(hi), 32'h1);
      if (vecs[v].exp_rd > 0)
        chk($sformatf("v%0d_last_addr", v), 32'(lastv),
            32'(vecs[v].exp_last));
      chk($sformatf("v%0d_busy_end", v), 32'(busy12), 32'h0);
    end

    // cs raised partway through the address
    clr_counts();
    cs = 1'b0;
    repeat (8) @(negedge clk);
    send_hdr(8'h03, 24'h000000, 12, hi);
    chk("abort_busy_before", 32'(busy12), 32'h1);
    cs = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_busy", 32'(busy12), 32'h0);
    chk("abort_miso", 32'(miso12), 32'h1);
    chk("abort_no_rd", 32'(rd_cnt12), 32'h0);
    repeat (8) @(negedge clk);
    clr_counts();
    run_xfer(8'h03, 24'h000001, 1, rx12, rx4, hi);
    chk("abort_reread", 32'(rx12), 32'h003C);
    chk("abort_reread_rd", 32'(rd_cnt12), 32'h2);

    // reset asserted during a data byte
    clr_counts();
    cs = 1'b0;
    repeat (8) @(negedge clk);
    send_hdr(8'h03, 24'h000000, 24, hi);
    rx12 = '0;
    for (int i = 0; i < 3; i++) begin
      spi_bit(1'b0, m12, m4);
      rx12 = {rx12[14:0], m12};
    end
    chk("rst_partial_bits", 32'(rx12), 32'h5);
    chk("rst_busy_before", 32'(busy12), 32'h1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_miso", 32'(miso12), 32'h1);
    chk("rst_busy", 32'(busy12), 32'h0);
    chk("rst_mem_rd", 32'(rd12), 32'h0);
    rst = 1'b0;
    clr_counts();
    all_hi = 1'b1;
    for (int i = 0; i < 8; i++) begin
      spi_bit(1'b0, m12, m4);
      all_hi = all_hi & m12;
      if (busy12) all_hi = 1'b0;
    end
    chk("rst_dropped_idle", 32'(all_hi), 32'h1);
    chk("rst_dropped_no_rd", 32'(rd_cnt12), 32'h0);
    cs = 1'b1;
    repeat (8) @(negedge clk);
    clr_counts();
    run_xfer(8'h03, 24'h000001, 1, rx12, rx4, hi);
    chk("rst_recover_data", 32'(rx12), 32'h003C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
